clk_div_prog: RTL and testbench

Runtime-programmable integer clock divider. It replaces the fixed compile-time divide-by-N block. It produces a 50%-duty divided clock for both even and odd divisors, using a negedge retiming flop for the odd case. A shadowed divisor register is applied only at a period boundary, so clk_out never glitches. The block also provides an enable, a per-period tick strobe, and illegal-configuration reporting. It sits in the clock-generation area and feeds low-rate peripheral clocks and tick-driven timers.

---
 rtl/clk_div_prog.sv | 90 +++++++++
 tb/tb_clk_div_prog.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Runtime-programmable 50%-duty integer clock divider with a shadowed divisor,
// enable, per-period tick and illegal-divisor reporting.
`timescale 1ns/1ps
module clk_div_prog #(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div_val,
  input  logic             div_load,
  output logic             clk_out,
  output logic             tick,
  output logic             pending,
  output logic             cfg_err,
  output logic [WIDTH-1:0] cur_div
);

  localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(RESET_DIV - 1);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);

  // High-phase length: ceil(d/2), one bit wider so 2^WIDTH-1 cannot overflow.
  function automatic logic [WIDTH:0] half_up(input logic [WIDTH-1:0] d);
    return ({1'b0, d} + {{WIDTH{1'b0}}, 1'b1}) >> 1;
  endfunction

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] shadow;
  logic             p;
  logic             n;

  logic             wrap;
  logic             swap;
  logic             load_ok;
  logic [WIDTH-1:0] cnt_nxt;
  logic [WIDTH-1:0] div_nxt;
  logic             p_nxt;

  always_comb begin
    wrap    = (cnt == act_div - ONE);
    swap    = wrap & pending;
    cnt_nxt = wrap ? '0 : cnt + ONE;
    div_nxt = swap ? shadow : act_div;
    p_nxt   = ({1'b0, cnt_nxt} < half_up(div_nxt));
    load_ok = div_load & (div_val >= MIN_DIV);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= RST_CNT;
      act_div <= RST_DIV;
      shadow  <= RST_DIV;
      p       <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= div_load & ~load_ok;
      if (en) begin
        cnt     <= cnt_nxt;
        act_div <= div_nxt;
        p       <= p_nxt;
        tick    <= wrap;
      end else begin
        tick    <= 1'b0;
      end
      // A load on a swapping wrap keeps pending set: it targets the next wrap.
      if (load_ok) begin
        shadow  <= div_val;
        pending <= 1'b1;
      end else if (en && swap) begin
        pending <= 1'b0;
      end
    end
  end

  // Half-cycle retimed copy of p; ANDed in for odd divisors to centre the duty.
  always_ff @(negedge clk or posedge rst) begin
    if (rst) n <= 1'b0;
    else     n <= p;
  end

  assign clk_out = act_div[0] ? (p & n) : p;
  assign cur_div = act_div;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a monitor measures each output period and
// high time against expected divisors queued by the stimulus sequence.
`timescale 1ns/1ps
module tb_clk_div_prog;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [7:0] div_val;
  logic       div_load;
  logic       clk_out;
  logic       tick;
  logic       pending;
  logic       cfg_err;
  logic [7:0] cur_div;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit mon_on = 1'b0;
  bit have_prev = 1'b0;
  int cyc_cnt = 0;
  time t_rise = 0;
  time high_ns = 0;

  clk_div_prog #(.WIDTH(8), .RESET_DIV(3)) dut (
    .clk(clk), .rst(rst), .en(en), .div_val(div_val), .div_load(div_load),
    .clk_out(clk_out), .tick(tick), .pending(pending), .cfg_err(cfg_err),
    .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // High time of the most recent clk_out pulse.
  initial begin
    forever begin
      @(posedge clk_out);
      t_rise = $time;
      @(negedge clk_out);
      high_ns = $time - t_rise;
    end
  end

  // At each tick, the period just ended must match the next queued divisor.
  initial begin
    int d;
    forever begin
      @(posedge clk);
      #1;
      cyc_cnt++;
      if (tick === 1'b1) begin
        if (mon_on && have_prev) begin
          checks++;
          assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed=0 expected=nonzero");
          end
          if (exp_q.size() != 0) begin
            d = exp_q.pop_front();
            chk("period_cycles", cyc_cnt, d);
            chk("high_ns", 32'(high_ns), 5 * d);
          end
        end
        have_prev = mon_on;
        cyc_cnt = 0;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b0; div_val = 8'd0; div_load = 1'b0;
    cyc(3);
    chk("rst_clk_out", clk_out, 0);
    chk("rst_tick", tick, 0);
    chk("rst_pending", pending, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_cur_div", cur_div, 3);

    // Divide by 3 from reset: first edge wraps.
    mon_on = 1'b1;
    exp_q.push_back(3); exp_q.push_back(3);
    rst = 1'b0; en = 1'b1;
    cyc(1);
    chk("e1_tick", tick, 1);
    chk("e1_clk_out_pre_negedge", clk_out, 0);
    @(negedge clk); #1;
    chk("e1_clk_out_post_negedge", clk_out, 1);
    cyc(1);
    chk("e2_tick", tick, 0);
    cyc(1);
    chk("e3_tick", tick, 0);
    chk("e3_clk_out", clk_out, 0);
    cyc(1);
    chk("e4_tick", tick, 1);
    cyc(3);

    // Load 4 mid-period.
    cyc(1);
    div_val = 8'd4; div_load = 1'b1;
    exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(4);
    cyc(1);
    div_load = 1'b0;
    chk("ld4_pending", pending, 1);
    chk("ld4_cur_old", cur_div, 3);
    cyc(1);
    chk("ld4_pending_clr", pending, 0);
    chk("ld4_cur_new", cur_div, 4);
    chk("ld4_tick", tick, 1);
    chk("ld4_clk_out", clk_out, 1);
    cyc(8);

    // Load 5 then 6 before the boundary: last write wins.
    div_val = 8'd5; div_load = 1'b1;
    exp_q.push_back(4); exp_q.push_back(6); exp_q.push_back(6);
    cyc(1);
    div_val = 8'd6;
    chk("ld56_cur_a", cur_div, 4);
    chk("ld56_pending_a", pending, 1);
    cyc(1);
    div_load = 1'b0;
    chk("ld56_cur_b", cur_div, 4);
    chk("ld56_pending_b", pending, 1);
    cyc(1);
    chk("ld56_cur_c", cur_div, 4);
    cyc(1);
    chk("ld56_cur_new", cur_div, 6);
    chk("ld56_pending_clr", pending, 0);
    chk("ld56_tick", tick, 1);
    cyc(12);

    // Illegal divisors 0 and 1.
    div_val = 8'd0; div_load = 1'b1;
    exp_q.push_back(6); exp_q.push_back(6);
    cyc(1);
    div_load = 1'b0;
    chk("ld0_cfg_err", cfg_err, 1);
    chk("ld0_pending", pending, 0);
    cyc(1);
    chk("ld0_cfg_err_clr", cfg_err, 0);
    div_val = 8'd1; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    chk("ld1_cfg_err", cfg_err, 1);
    cyc(1);
    chk("ld1_cfg_err_clr", cfg_err, 0);
    chk("ld1_pending", pending, 0);
    chk("ld1_cur", cur_div, 6);
    cyc(7);

    // Load 7 on the exact wrap edge.
    div_val = 8'd7; div_load = 1'b1;
    exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(7);
    cyc(1);
    div_load = 1'b0;
    chk("ld7_wrap_tick", tick, 1);
    chk("ld7_cur_old", cur_div, 6);
    chk("ld7_pending", pending, 1);
    cyc(6);
    chk("ld7_tick", tick, 1);
    chk("ld7_cur_new", cur_div, 7);
    chk("ld7_pending_clr", pending, 0);
    cyc(14);
    chk("e66_tick", tick, 1);

    // Freeze with clk_out high.
    cyc(1);
    chk("pre_freeze_clk_out", clk_out, 1);
    mon_on = 1'b0;
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("freeze_clk_out", clk_out, 1);
      chk("freeze_tick", tick, 0);
    end
    en = 1'b1;
    cyc(2);
    chk("resume_clk_out_high", clk_out, 1);
    cyc(1);
    chk("resume_clk_out_fall", clk_out, 0);
    cyc(3);
    chk("resume_tick", tick, 1);

    // Reset mid-period with a divisor pending.
    div_val = 8'd5; div_load = 1'b1;
    cyc(1);
    div_load = 1'b0;
    chk("prerst_pending", pending, 1);
    chk("prerst_clk_out", clk_out, 1);
    rst = 1'b1;
    #1;
    chk("rst_async_clk_out", clk_out, 0);
    chk("rst_async_pending", pending, 0);
    chk("rst_async_cur", cur_div, 3);
    mon_on = 1'b1;
    exp_q.push_back(3); exp_q.push_back(3);
    cyc(1);
    chk("rst_hold_clk_out", clk_out, 0);
    chk("rst_hold_tick", tick, 0);
    rst = 1'b0;
    cyc(1);
    chk("post_rst_tick", tick, 1);
    chk("post_rst_cur", cur_div, 3);
    @(negedge clk); #1;
    chk("post_rst_clk_out", clk_out, 1);
    cyc(6);
    #2;
    chk("sb_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
